beacon_tx_sequencer: RTL and testbench

//  Consumer end of the orbit transmit window: takes tx_enable from the orbit controller and sequences the radio.

---
 rtl/beacon_tx_sequencer_pkg.sv | 26 ++
 rtl/beacon_tx_sequencer_tick_timer.sv | 40 ++++
 rtl/beacon_tx_sequencer.sv | 157 +++++++++++++++
 tb/tb_beacon_tx_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/beacon_tx_sequencer_pkg.sv
// Shared definitions for the beacon transmit sequencer: FSM state encodings,
// counter widths and saturating-increment helpers.
package beacon_tx_sequencer_pkg;

  localparam int SEQ_W  = 16;
  localparam int SENT_W = 16;
  localparam int TOUT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WARMUP   = 3'd1,
    ST_REQ      = 3'd2,
    ST_GAP      = 3'd3,
    ST_COOLDOWN = 3'd4
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [SENT_W-1:0] sat_inc_sent(input logic [SENT_W-1:0] v);
    return (&v) ? v : v + SENT_W'(1);
  endfunction

  function automatic logic [TOUT_W-1:0] sat_inc_tout(input logic [TOUT_W-1:0] v);
    return (&v) ? v : v + TOUT_W'(1);
  endfunction

endpackage

// File: rtl/beacon_tx_sequencer_tick_timer.sv
// Tick down-counter: loaded in the first cycle of a state (a tick in that
// cycle is swallowed), decremented on every later tick, and producing a
// single-cycle expire pulse in the cycle carrying the terminal tick.
module beacon_tx_sequencer_tick_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         tick_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load wins over tick; an exhausted counter stays at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (tick_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Terminal count: the tick that takes the counter from 1 to 0.
  assign expire_o = !load_i && tick_i && (cnt_q == W'(1));

endmodule

// File: rtl/beacon_tx_sequencer.sv
// Beacon transmit sequencer: powers the radio for an orbit transmit window,
// waits out PA warm-up, issues numbered packet requests to the framer with a
// fixed gap, and cools the radio down once the window closes.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | radio off, waiting for tx_enable
// WARMUP   | radio powered, waiting WARMUP_TICKS for the PA
// REQ      | pkt_req high, waiting for ack or ACK_TIMEOUT ticks
// GAP      | spacing between packets, GAP_TICKS
// COOLDOWN | radio still powered for COOLDOWN_TICKS, then off
module beacon_tx_sequencer
  import beacon_tx_sequencer_pkg::*;
#(
  parameter int WARMUP_TICKS   = 20,
  parameter int GAP_TICKS      = 50,
  parameter int ACK_TIMEOUT    = 30,
  parameter int COOLDOWN_TICKS = 10,
  parameter int TIMER_W        = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_i,
  input  logic              tx_enable_i,
  input  logic              pkt_ack_i,
  output logic              radio_pwr_en_o,
  output logic              pkt_req_o,
  output logic [SEQ_W-1:0]  pkt_seq_o,
  output logic [SENT_W-1:0] pkts_sent_o,
  output logic [TOUT_W-1:0] timeout_cnt_o,
  output logic              busy_o
);

  state_e state_q, state_d;

  logic               entry_q;
  logic               pwr_q, pwr_d;
  logic               req_q, req_d;
  logic               busy_q, busy_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic [SENT_W-1:0]  sent_q, sent_d;
  logic [TOUT_W-1:0]  tout_q, tout_d;

  logic [TIMER_W-1:0] load_val;
  logic               expire;
  logic               ack_evt;
  logic               tout_evt;

  // Ack only counts while a request is actually outstanding; an ack arriving
  // together with the terminal tick is treated as an ack, not a timeout.
  assign ack_evt  = (state_q == ST_REQ) && req_q && pkt_ack_i;
  assign tout_evt = (state_q == ST_REQ) && expire && !ack_evt;

  // Timer reload value for the state just entered.
  always_comb begin
    load_val = '0;
    case (state_q)
      ST_WARMUP:   load_val = TIMER_W'(WARMUP_TICKS);
      ST_REQ:      load_val = TIMER_W'(ACK_TIMEOUT);
      ST_GAP:      load_val = TIMER_W'(GAP_TICKS);
      ST_COOLDOWN: load_val = TIMER_W'(COOLDOWN_TICKS);
      default:     load_val = '0;
    endcase
  end

  beacon_tx_sequencer_tick_timer #(
    .W(TIMER_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (entry_q),
    .load_val_i (load_val),
    .tick_i     (tick_i),
    .expire_o   (expire)
  );

  // State register plus the first-cycle-of-state flag that arms the timer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      entry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= (state_d != state_q);
    end
  end

  // Next-state logic; a closing window never aborts an open handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (tx_enable_i) state_d = ST_WARMUP;
      end
      ST_WARMUP: begin
        if (!tx_enable_i)  state_d = ST_COOLDOWN;
        else if (expire)   state_d = ST_REQ;
      end
      ST_REQ: begin
        if (ack_evt || tout_evt) state_d = tx_enable_i ? ST_GAP : ST_COOLDOWN;
      end
      ST_GAP: begin
        if (!tx_enable_i)  state_d = ST_COOLDOWN;
        else if (expire)   state_d = ST_REQ;
      end
      ST_COOLDOWN: begin
        if (expire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output next values, derived from the next state so outputs change in
  // the same cycle the state does.
  always_comb begin
    pwr_d  = (state_d != ST_IDLE);
    busy_d = (state_d != ST_IDLE);
    req_d  = (state_d == ST_REQ);
    seq_d  = seq_q;
    sent_d = sent_q;
    tout_d = tout_q;
    if (ack_evt) begin
      seq_d  = seq_q + SEQ_W'(1);
      sent_d = sat_inc_sent(sent_q);
    end
    if (tout_evt) begin
      tout_d = sat_inc_tout(tout_q);
    end
  end

  // Output and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwr_q  <= 1'b0;
      busy_q <= 1'b0;
      req_q  <= 1'b0;
      seq_q  <= '0;
      sent_q <= '0;
      tout_q <= '0;
    end else begin
      pwr_q  <= pwr_d;
      busy_q <= busy_d;
      req_q  <= req_d;
      seq_q  <= seq_d;
      sent_q <= sent_d;
      tout_q <= tout_d;
    end
  end

  assign radio_pwr_en_o = pwr_q;
  assign busy_o         = busy_q;
  assign pkt_req_o      = req_q;
  assign pkt_seq_o      = seq_q;
  assign pkts_sent_o    = sent_q;
  assign timeout_cnt_o  = tout_q;

endmodule

// File: tb/tb_beacon_tx_sequencer.sv
// Directed bench for beacon_tx_sequencer with default parameters.
module tb_beacon_tx_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick_i;
  logic        tx_enable_i;
  logic        pkt_ack_i;
  logic        radio_pwr_en_o;
  logic        pkt_req_o;
  logic [15:0] pkt_seq_o;
  logic [15:0] pkts_sent_o;
  logic [7:0]  timeout_cnt_o;
  logic        busy_o;

  int n_cmp = 0;
  int n_err = 0;

  beacon_tx_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .tick_i         (tick_i),
    .tx_enable_i    (tx_enable_i),
    .pkt_ack_i      (pkt_ack_i),
    .radio_pwr_en_o (radio_pwr_en_o),
    .pkt_req_o      (pkt_req_o),
    .pkt_seq_o      (pkt_seq_o),
    .pkts_sent_o    (pkts_sent_o),
    .timeout_cnt_o  (timeout_cnt_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each tick lands one cycle after the current negedge; returns on the
  // negedge right after the tick has been clocked in.
  task automatic tick_n(input int n);
    repeat (n) begin
      @(negedge clk);
      tick_i = 1'b1;
      @(negedge clk);
      tick_i = 1'b0;
    end
  endtask

  task automatic ack_pulse();
    pkt_ack_i = 1'b1;
    @(negedge clk);
    pkt_ack_i = 1'b0;
  endtask

  initial begin
    reset = 1'b0; tick_i = 1'b0; tx_enable_i = 1'b0; pkt_ack_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pwr",  radio_pwr_en_o, 0);
    check("rst_req",  pkt_req_o, 0);
    check("rst_seq",  pkt_seq_o, 0);
    check("rst_busy", busy_o, 0);
    reset = 1'b1;
    @(negedge clk);

    // Window opens: power in the WARMUP entry cycle, first req on tick 20.
    tx_enable_i = 1'b1;
    @(negedge clk);
    check("warm_pwr",  radio_pwr_en_o, 1);
    check("warm_busy", busy_o, 1);
    check("warm_req",  pkt_req_o, 0);
    tick_i = 1'b1;                     // tick in entry cycle is not counted
    @(negedge clk);
    tick_i = 1'b0;
    tick_n(19);
    check("warm_t19_req", pkt_req_o, 0);
    tick_n(1);
    check("warm_t20_req", pkt_req_o, 1);
    check("req0_seq",     pkt_seq_o, 16'h0000);

    // Ack three cycles after request.
    @(negedge clk); @(negedge clk);
    ack_pulse();
    check("ack0_req",  pkt_req_o, 0);
    check("ack0_seq",  pkt_seq_o, 16'h0001);
    check("ack0_sent", pkts_sent_o, 1);
    tick_n(49);
    check("gap_t49_req", pkt_req_o, 0);
    tick_n(1);
    check("gap_t50_req", pkt_req_o, 1);
    check("req1_seq",    pkt_seq_o, 16'h0001);
    @(negedge clk); @(negedge clk);
    ack_pulse();
    check("ack1_seq",  pkt_seq_o, 16'h0002);
    check("ack1_sent", pkts_sent_o, 2);
    tick_n(50);
    check("req2_req", pkt_req_o, 1);
    check("req2_seq", pkt_seq_o, 16'h0002);

    // No ack: timeout on tick 30, retry with same sequence number.
    tick_n(29);
    check("to_t29_req", pkt_req_o, 1);
    tick_n(1);
    check("to_t30_req",  pkt_req_o, 0);
    check("to_cnt",      timeout_cnt_o, 1);
    check("to_seq",      pkt_seq_o, 16'h0002);
    check("to_sent",     pkts_sent_o, 2);
    tick_n(49);
    check("retry_t49_req", pkt_req_o, 0);
    tick_n(1);
    check("retry_req", pkt_req_o, 1);
    check("retry_seq", pkt_seq_o, 16'h0002);

    // Window closes mid-request; handshake still completes, then cooldown.
    tx_enable_i = 1'b0;
    tick_n(5);
    check("close_req_held", pkt_req_o, 1);
    ack_pulse();
    check("close_req",  pkt_req_o, 0);
    check("close_sent", pkts_sent_o, 3);
    check("close_seq",  pkt_seq_o, 16'h0003);
    check("cool_pwr",   radio_pwr_en_o, 1);
    check("cool_busy",  busy_o, 1);
    tick_n(9);
    check("cool_t9_pwr", radio_pwr_en_o, 1);
    tick_n(1);
    check("cool_t10_pwr",  radio_pwr_en_o, 0);
    check("cool_t10_busy", busy_o, 0);
    repeat (3) @(negedge clk);
    check("idle_stay_busy", busy_o, 0);

    // Window closes in WARMUP after tick 7; re-raise during cooldown.
    tx_enable_i = 1'b1;
    @(negedge clk);
    check("w2_pwr", radio_pwr_en_o, 1);
    tick_n(7);
    tx_enable_i = 1'b0;
    @(negedge clk);
    check("w2_abort_req",  pkt_req_o, 0);
    check("w2_abort_pwr",  radio_pwr_en_o, 1);
    check("w2_abort_busy", busy_o, 1);
    tx_enable_i = 1'b1;
    tick_n(9);
    check("w2_cool_t9_pwr", radio_pwr_en_o, 1);
    check("w2_cool_t9_req", pkt_req_o, 0);
    tick_n(1);
    check("w2_idle_pwr",  radio_pwr_en_o, 0);
    check("w2_idle_busy", busy_o, 0);
    @(negedge clk);
    check("w2_restart_pwr", radio_pwr_en_o, 1);
    check("w2_restart_req", pkt_req_o, 0);

    // Sequence wrap: preload 0xFFFF during WARMUP.
    force dut.seq_q = 16'hFFFF;
    #1;
    release dut.seq_q;
    check("preload_seq", pkt_seq_o, 16'hFFFF);
    tick_n(20);
    check("wrap_req", pkt_req_o, 1);
    ack_pulse();
    check("wrap_seq",  pkt_seq_o, 16'h0000);
    check("wrap_sent", pkts_sent_o, 4);

    // Ack in the same cycle as the terminal timeout tick counts as ack.
    tick_n(50);
    check("same_req", pkt_req_o, 1);
    tick_n(29);
    @(negedge clk);
    tick_i = 1'b1; pkt_ack_i = 1'b1;
    @(negedge clk);
    tick_i = 1'b0; pkt_ack_i = 1'b0;
    check("same_req_drop", pkt_req_o, 0);
    check("same_tout",     timeout_cnt_o, 1);
    check("same_sent",     pkts_sent_o, 5);
    check("same_seq",      pkt_seq_o, 16'h0001);

    // Reset in the middle of a request.
    tick_n(50);
    check("pre_rst_req", pkt_req_o, 1);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_req",  pkt_req_o, 0);
    check("mid_rst_pwr",  radio_pwr_en_o, 0);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_seq",  pkt_seq_o, 0);
    check("mid_rst_sent", pkts_sent_o, 0);
    check("mid_rst_tout", timeout_cnt_o, 0);
    repeat (5) @(negedge clk);
    check("held_rst_pwr",  radio_pwr_en_o, 0);
    check("held_rst_busy", busy_o, 0);
    check("held_rst_req",  pkt_req_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
